// File: rtl/button_conditioner_pkg.sv
// Shared types and defaults for the pushbutton conditioner.
// Holds the per-button FSM state encoding.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    HELD         = 2'd2,
    RELEASE_PEND = 2'd3
  } btn_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_MOVE_DIV        = 1666667;

endpackage

// File: rtl/button_conditioner_if.sv
// Raw buttons in, conditioned levels/pulses/tick out.
// slave = conditioner side, master = board/consumer side.
interface button_conditioner_if;

  logic btnU, btnD, btnL, btnR, btnC;
  logic up, down, left, right, center;
  logic up_p, down_p, left_p, right_p, center_p;
  logic move_tick;

  modport slave (
    input  btnU, btnD, btnL, btnR, btnC,
    output up, down, left, right, center,
    output up_p, down_p, left_p, right_p, center_p,
    output move_tick
  );

  modport master (
    output btnU, btnD, btnL, btnR, btnC,
    input  up, down, left, right, center,
    input  up_p, down_p, left_p, right_p, center_p,
    input  move_tick
  );

endinterface

// File: rtl/button_debounce.sv
// One button: 2-flop synchronizer, debounce FSM,
// registered level and single-cycle press pulse.
module button_debounce
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q, sync_q;
  btn_state_t    state_q, state_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic          level_nxt, pulse_nxt;

  // Two-flop synchronizer for the asynchronous raw input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      level   <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      level   <= level_nxt;
      pulse   <= pulse_nxt;
    end
  end

  // Next state: a change is accepted only after a stable run.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    unique case (state_q)
      RELEASED: begin
        if (sync_q) begin
          state_nxt = PRESS_PEND;
          cnt_nxt   = '0;
        end
      end
      PRESS_PEND: begin
        if (!sync_q)
          state_nxt = RELEASED;
        else if (cnt_q == CNT_MAX)
          state_nxt = HELD;
        else
          cnt_nxt = cnt_q + CW'(1);
      end
      HELD: begin
        if (!sync_q) begin
          state_nxt = RELEASE_PEND;
          cnt_nxt   = '0;
        end
      end
      RELEASE_PEND: begin
        if (sync_q)
          state_nxt = HELD;
        else if (cnt_q == CNT_MAX)
          state_nxt = RELEASED;
        else
          cnt_nxt = cnt_q + CW'(1);
      end
    endcase
    level_nxt = (state_nxt == HELD) ||
                (state_nxt == RELEASE_PEND);
    pulse_nxt = (state_q == PRESS_PEND) &&
                (state_nxt == HELD);
  end

endmodule

// File: rtl/button_conditioner.sv
// Five debounced pushbuttons plus a free-running
// move_tick strobe that paces object motion.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned MOVE_DIV        = DEF_MOVE_DIV
) (
  input  logic               clk,
  input  logic               rst,
  button_conditioner_if.slave bus
);

  localparam int DW = $clog2(MOVE_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(MOVE_DIV - 1);

  logic [DW-1:0] div_q, div_nxt;
  logic          tick_q;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk(clk), .rst(rst), .raw(bus.btnU),
    .level(bus.up), .pulse(bus.up_p)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk(clk), .rst(rst), .raw(bus.btnD),
    .level(bus.down), .pulse(bus.down_p)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk(clk), .rst(rst), .raw(bus.btnL),
    .level(bus.left), .pulse(bus.left_p)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk(clk), .rst(rst), .raw(bus.btnR),
    .level(bus.right), .pulse(bus.right_p)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_center (
    .clk(clk), .rst(rst), .raw(bus.btnC),
    .level(bus.center), .pulse(bus.center_p)
  );

  // Divider wraps at MOVE_DIV-1.
  always_comb begin
    div_nxt = div_q + DW'(1);
    if (div_q == DIV_MAX)
      div_nxt = '0;
  end

  // Tick register tracks the count it sits beside.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_nxt;
      tick_q <= (div_nxt == DIV_MAX);
    end
  end

  assign bus.move_tick = tick_q;

endmodule
